traffic_phase_scheduler: RTL

//  Timed phase sequencer for the highway/country intersection. It drives both signal heads with

---
 rtl/traffic_pkg.sv | 22 ++
 rtl/phase_timer.sv | 37 +++
 rtl/traffic_phase_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared encodings for the highway/country intersection blocks.
//   light_t : signal-head lamp code (RED/YELLOW/GREEN)
//   phase_t : scheduler state code, also exported as the debug phase output
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

    typedef enum logic [2:0] {
        HWY_GREEN    = 3'd0,
        HWY_YELLOW   = 3'd1,
        HWY_CLEAR    = 3'd2,
        CNTRY_GREEN  = 3'd3,
        CNTRY_YELLOW = 3'd4,
        CNTRY_CLEAR  = 3'd5,
        WALK         = 3'd6
    } phase_t;

endpackage

// File: rtl/phase_timer.sv
// phase_timer: saturating cycle counter for the current phase.
//   clk_i     : rising-edge clock
//   rst_i     : asynchronous active-high reset, count -> 0
//   restart_i : load 0 on this edge (asserted on every state entry)
//   count_o   : cycles elapsed in the current phase, sticks at all-ones
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             restart_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (restart_i) begin
            count_d = '0;
        end else if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: timed Moore sequencer for both signal heads.
//   clk     : rising-edge clock
//   clear   : asynchronous active-high reset
//   x       : country-road car sensor (level)
//   ped_req : pedestrian request, latched until the walk phase is entered
//   emg     : emergency pre-empt, forces highway priority
//   hwy     : highway head lamp code
//   cntry   : country head lamp code
//   walk    : pedestrian walk lamp
//   phase   : current state code (debug)
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CNT_W           = 4,
    parameter int MIN_HWY_GREEN   = 8,
    parameter int YELLOW_T        = 3,
    parameter int ALLRED_T        = 2,
    parameter int MAX_CNTRY_GREEN = 10,
    parameter int WALK_T          = 6
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       x,
    input  logic       ped_req,
    input  logic       emg,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk,
    output logic [2:0] phase
);

    // Last timer value of each phase: a phase of length T exits at timer==T-1.
    localparam logic [CNT_W-1:0] HWY_G_LAST   = CNT_W'(MIN_HWY_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] CNTRY_G_LAST = CNT_W'(MAX_CNTRY_GREEN - 1);
    localparam logic [CNT_W-1:0] WALK_LAST    = CNT_W'(WALK_T - 1);

    phase_t           state_q, state_d;
    logic             ped_q, ped_d;
    logic [CNT_W-1:0] timer;
    logic             restart;

    // Any change of state restarts the phase timer on the same edge.
    assign restart = (state_d != state_q);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i     (clk),
        .rst_i     (clear),
        .restart_i (restart),
        .count_o   (timer)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            HWY_GREEN: begin
                // timer may sit saturated here while waiting for demand
                if (timer >= HWY_G_LAST && (x || ped_q) && !emg)
                    state_d = HWY_YELLOW;
            end
            HWY_YELLOW: begin
                if (timer == YELLOW_LAST) state_d = HWY_CLEAR;
            end
            HWY_CLEAR: begin
                if (timer == ALLRED_LAST) begin
                    if (emg)        state_d = HWY_GREEN;
                    else if (x)     state_d = CNTRY_GREEN;
                    else if (ped_q) state_d = WALK;
                    else            state_d = HWY_GREEN;
                end
            end
            CNTRY_GREEN: begin
                if (!x || emg || timer == CNTRY_G_LAST) state_d = CNTRY_YELLOW;
            end
            CNTRY_YELLOW: begin
                if (timer == YELLOW_LAST) state_d = CNTRY_CLEAR;
            end
            CNTRY_CLEAR: begin
                if (timer == ALLRED_LAST)
                    state_d = (ped_q && !emg) ? WALK : HWY_GREEN;
            end
            WALK: begin
                if (timer == WALK_LAST) state_d = HWY_GREEN;
            end
            default: state_d = HWY_GREEN;
        endcase
    end

    // Entering WALK consumes the request; that clear beats a coincident new request.
    always_comb begin
        ped_d = ped_q;
        if (state_d == WALK && state_q != WALK) begin
            ped_d = 1'b0;
        end else if (ped_req && state_q != WALK) begin
            ped_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= HWY_GREEN;
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ped_q   <= ped_d;
        end
    end

    always_comb begin
        hwy   = RED;
        cntry = RED;
        walk  = 1'b0;
        case (state_q)
            HWY_GREEN:    hwy   = GREEN;
            HWY_YELLOW:   hwy   = YELLOW;
            CNTRY_GREEN:  cntry = GREEN;
            CNTRY_YELLOW: cntry = YELLOW;
            WALK:         walk  = 1'b1;
            default:      ;
        endcase
    end

    assign phase = state_q;

endmodule
